// File: rtl/beta_fetch_if.sv
// Instruction-memory read port between the Beta fetch unit (master) and imem (slave).
interface beta_fetch_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, imem_req, input  imem_ack, imem_rdata);
    modport slave  (input  imem_addr, imem_req, output imem_ack, imem_rdata);
endinterface

// File: rtl/beta_fetch_unit.sv
// Beta instruction-fetch stage: holds the PC, issues imem word reads with a
// bounded wait, latches the instruction and computes the next PC on request.
module beta_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [31:0] RESET_VEC      = 32'h80000000,
    parameter logic [31:0] ILLOP_VEC      = 32'h80000004,
    parameter logic [31:0] XADR_VEC       = 32'h80000008
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_start,
    input  logic               pc_update,
    input  logic [2:0]         pc_sel,
    input  logic               br_taken,
    input  logic [31:0]        ra_data,
    beta_fetch_if.master       imem,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic               fetch_busy,
    output logic               fetch_fault,
    output logic               protocol_err
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic        req_q;
    logic        do_fetch, do_update, do_latch, do_abort, cnt_inc, perr;
    logic [31:0] br_off, br_tgt, npc, pc_nxt;

    assign imem.imem_addr = addr_q;
    assign imem.imem_req  = req_q;
    assign fetch_busy     = (state == REQ);

    // Supervisor bit pc[31] rides through sequential and branch arithmetic untouched.
    assign pc_plus4 = (pc & 32'h80000000) | ((pc + 32'd4) & 32'h7FFFFFFF);
    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_tgt   = (pc & 32'h80000000) | ((pc_plus4 + br_off) & 32'h7FFFFFFF);

    always_comb begin
        npc = ILLOP_VEC;
        case (pc_sel)
            3'd0:    npc = pc_plus4;
            3'd1:    npc = br_taken ? br_tgt : pc_plus4;
            // A user-mode jump can never set the supervisor bit.
            3'd2:    npc = {pc[31] & ra_data[31], ra_data[30:0]};
            3'd4:    npc = XADR_VEC;
            3'd5:    npc = RESET_VEC;
            default: npc = ILLOP_VEC;
        endcase
        pc_nxt = npc & ~32'h3;
    end

    always_comb begin
        state_nxt = state;
        do_fetch  = 1'b0;
        do_update = 1'b0;
        do_latch  = 1'b0;
        do_abort  = 1'b0;
        cnt_inc   = 1'b0;
        perr      = 1'b0;
        case (state)
            REQ: begin
                perr = fetch_start | pc_update;
                if (imem.imem_ack) begin
                    do_latch  = 1'b1;
                    state_nxt = HOLD;
                end else if (wait_cnt == LAST_CNT) begin
                    do_abort  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                if (pc_update) begin
                    do_update = 1'b1;
                    perr      = fetch_start;
                    state_nxt = IDLE;
                end else if (fetch_start) begin
                    do_fetch  = 1'b1;
                    state_nxt = REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_VEC;
            addr_q       <= RESET_VEC;
            req_q        <= 1'b0;
            instr        <= 32'h0;
            instr_valid  <= 1'b0;
            fetch_fault  <= 1'b0;
            protocol_err <= 1'b0;
            wait_cnt     <= 8'd0;
        end else begin
            state       <= state_nxt;
            fetch_fault <= do_abort;
            if (perr)
                protocol_err <= 1'b1;
            if (cnt_inc)
                wait_cnt <= wait_cnt + 8'd1;
            if (do_fetch) begin
                req_q       <= 1'b1;
                addr_q      <= {pc[31:2], 2'b00};
                instr_valid <= 1'b0;
                wait_cnt    <= 8'd0;
            end
            if (do_latch) begin
                instr       <= imem.imem_rdata;
                instr_valid <= 1'b1;
                req_q       <= 1'b0;
            end
            if (do_abort) begin
                req_q       <= 1'b0;
                instr_valid <= 1'b0;
            end
            if (do_update) begin
                pc          <= pc_nxt;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Directed bench for beta_fetch_unit: a reference model checked on every cycle
// plus literal expectations taken from hand-worked examples.
module tb_beta_fetch_unit;
    localparam int TO = 4;
    localparam logic [31:0] RV = 32'h80000000;

    logic        clk, reset, fetch_start, pc_update, br_taken;
    logic [2:0]  pc_sel;
    logic [31:0] ra_data, pc, pc_plus4, instr;
    logic        instr_valid, fetch_busy, fetch_fault, protocol_err;
    int checks = 0, failures = 0;
    bit cmp_on = 0;

    beta_fetch_if bus();

    beta_fetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_update(pc_update),
        .pc_sel(pc_sel), .br_taken(br_taken), .ra_data(ra_data), .imem(bus),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
        .fetch_busy(fetch_busy), .fetch_fault(fetch_fault), .protocol_err(protocol_err));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC kept as plain 32-bit arithmetic, fetch as "in flight / cycles waited".
    function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [31:0] ins,
                                            input logic [31:0] ra, input logic [2:0] sel,
                                            input logic bt);
        logic [31:0] s, off;
        s   = p & 32'h80000000;
        off = 32'($signed(ins[15:0])) << 2;
        case (sel)
            3'd0: return s | ((p + 4) & 32'h7FFFFFFC);
            3'd1: return bt ? (s | ((p + 4 + off) & 32'h7FFFFFFC)) : (s | ((p + 4) & 32'h7FFFFFFC));
            3'd2: return (p & ra & 32'h80000000) | (ra & 32'h7FFFFFFC);
            3'd4: return 32'h80000008;
            3'd5: return 32'h80000000;
            default: return 32'h80000004;
        endcase
    endfunction

    logic [31:0] m_pc, m_addr, m_instr;
    logic        m_busy, m_valid, m_fault, m_perr;
    int          m_waited;

    always @(posedge clk) begin
        if (!reset) begin
            m_pc <= RV; m_addr <= RV; m_instr <= 0; m_busy <= 0;
            m_valid <= 0; m_fault <= 0; m_perr <= 0; m_waited <= 0;
        end else begin
            m_fault <= 0;
            if (m_busy) begin
                if (fetch_start || pc_update) m_perr <= 1;
                if (bus.imem_ack) begin
                    m_instr <= bus.imem_rdata; m_valid <= 1; m_busy <= 0;
                end else if (m_waited + 1 == TO) begin
                    m_busy <= 0; m_fault <= 1; m_valid <= 0;
                end else m_waited <= m_waited + 1;
            end else if (pc_update) begin
                m_pc <= ref_npc(m_pc, m_instr, ra_data, pc_sel, br_taken);
                m_valid <= 0;
                if (fetch_start) m_perr <= 1;
            end else if (fetch_start) begin
                m_busy <= 1; m_addr <= m_pc & ~32'h3; m_valid <= 0; m_waited <= 0;
            end
        end
    end

    always @(negedge clk) if (cmp_on) begin
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, (m_pc & 32'h80000000) | ((m_pc + 4) & 32'h7FFFFFFF));
        chk("instr", instr, m_instr);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("imem_req", 32'(bus.imem_req), 32'(m_busy));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_busy));
        chk("imem_addr", bus.imem_addr, m_addr);
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        chk("protocol_err", 32'(protocol_err), 32'(m_perr));
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic fetch(input int delay, input logic [31:0] data);
        fetch_start = 1; cyc(); fetch_start = 0;
        for (int i = 0; i < delay; i++) cyc();
        bus.imem_ack = 1; bus.imem_rdata = data; cyc(); bus.imem_ack = 0;
    endtask

    task automatic upd(input logic [2:0] sel, input logic bt, input logic [31:0] ra);
        pc_update = 1; pc_sel = sel; br_taken = bt; ra_data = ra;
        cyc(); pc_update = 0;
    endtask

    initial begin
        reset = 0; fetch_start = 0; pc_update = 0; pc_sel = 0; br_taken = 0; ra_data = 0;
        bus.imem_ack = 0; bus.imem_rdata = 0;
        cyc(); cmp_on = 1; cyc();
        chk("rst_pc", pc, 32'h80000000);
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        reset = 1; cyc();

        fetch(2, 32'hC3E00005);
        chk("f_addr", bus.imem_addr, 32'h80000000);
        chk("f_instr", instr, 32'hC3E00005);
        chk("f_valid", 32'(instr_valid), 1);
        chk("f_busy", 32'(fetch_busy), 0);

        upd(0, 0, 0);             chk("inc1", pc, 32'h80000004);
        upd(2, 0, 32'h7FFFFFFC);  chk("jmp_lo", pc, 32'h7FFFFFFC);
        upd(0, 0, 0);             chk("inc_wrap_u", pc, 32'h00000000);
        upd(5, 0, 0);             chk("rst_sel", pc, 32'h80000000);
        upd(2, 0, 32'hFFFFFFFC);  chk("jmp_hi", pc, 32'hFFFFFFFC);
        upd(0, 0, 0);             chk("inc_wrap_s", pc, 32'h80000000);

        upd(2, 0, 32'h00000100);  chk("jmp_100", pc, 32'h00000100);
        fetch(0, 32'h7BFFFFFE);
        upd(1, 1, 0);             chk("br_taken", pc, 32'h000000FC);
        upd(2, 0, 32'h00000100);
        upd(1, 0, 0);             chk("br_not", pc, 32'h00000104);

        upd(2, 0, 32'h00000200);
        upd(2, 0, 32'h80001237);  chk("jmp_user", pc, 32'h00001234);
        upd(5, 0, 0);
        upd(2, 0, 32'h80000200);
        upd(2, 0, 32'h80001237);  chk("jmp_sup", pc, 32'h80001234);
        upd(3, 0, 0);             chk("illop", pc, 32'h80000004);
        upd(4, 0, 0);             chk("xadr", pc, 32'h80000008);
        upd(7, 0, 0);             chk("sel7", pc, 32'h80000004);

        bus.imem_ack = 1; bus.imem_rdata = 32'hDEADBEEF; cyc(); bus.imem_ack = 0;
        chk("stray_ack", instr, 32'h7BFFFFFE);

        fetch_start = 1; cyc(); fetch_start = 0;
        for (int k = 0; k < TO; k++) begin chk("to_req", 32'(bus.imem_req), 1); cyc(); end
        chk("to_fault", 32'(fetch_fault), 1);
        chk("to_req_low", 32'(bus.imem_req), 0);
        chk("to_valid", 32'(instr_valid), 0);
        chk("to_instr", instr, 32'h7BFFFFFE);
        cyc();
        chk("to_pulse", 32'(fetch_fault), 0);

        fetch(TO - 1, 32'h12345678);
        chk("late_instr", instr, 32'h12345678);
        chk("late_valid", 32'(instr_valid), 1);
        chk("late_fault", 32'(fetch_fault), 0);

        fetch_start = 1; cyc(); fetch_start = 1; cyc(); fetch_start = 0;
        chk("perr_set", 32'(protocol_err), 1);
        chk("perr_busy", 32'(fetch_busy), 1);
        bus.imem_ack = 1; bus.imem_rdata = 32'hA5A5A5A5; cyc(); bus.imem_ack = 0;
        cyc();
        chk("perr_sticky", 32'(protocol_err), 1);
        chk("perr_instr", instr, 32'hA5A5A5A5);

        fetch_start = 1; cyc(); fetch_start = 0;
        reset = 0; cyc(); reset = 1;
        chk("mid_rst_req", 32'(bus.imem_req), 0);
        chk("mid_rst_pc", pc, 32'h80000000);
        chk("mid_rst_perr", 32'(protocol_err), 0);
        cyc();

        upd(2, 0, 32'h00000040);
        fetch_start = 1; pc_update = 1; pc_sel = 0; cyc(); fetch_start = 0; pc_update = 0;
        chk("both_pc", pc, 32'h00000044);
        chk("both_perr", 32'(protocol_err), 1);
        chk("both_busy", 32'(fetch_busy), 0);
        cyc(); cyc();

        cmp_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
